core_boot_ctrl: RTL
===================

# core_boot_ctrl

Parametrised boot and observation controller placed beside the five-stage pipelined core in the top level. It replaces the raw instruction-memory write port (din/addr/active-low web) with a valid/ready program-load stream, holds the core in reset while loading, then releases it. It also captures every data-memory store the core issues (address, data) into a FIFO that a bench or debug host drains through a second valid/ready stream.

## Interface
Parameters:
- XLEN, 32, data/address width of core buses
- IMEM_AW, 10, instruction memory word-address bits; capacity CAP = 2^IMEM_AW words
- TRACE_DEPTH, 8, store-trace FIFO entries (power of 2, ≥2)
- BOOT_ADDR, 0, byte address of first loaded word (word aligned)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- ld_start  in  1  pulse: begin new load session
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted when ld_valid && ld_ready
- ld_data  in  XLEN  instruction word
- ld_last  in  1  marks final word of session
- imem_din  out  XLEN  write data to instruction memory
- imem_addr  out  XLEN  byte address to instruction memory
- imem_web  out  1  instruction memory write enable, active-low
- core_rstn  out  1  core reset, active-low
- load_count  out  IMEM_AW+1  words written in current/last session
- ld_trunc  out  1  session ended on capacity without ld_last
- mem_wrM  in  1  core store strobe (memory stage)
- ALU_resultM  in  XLEN  store address
- wr_dataM  in  XLEN  store data
- tr_valid  out  1  trace entry available
- tr_ready  in  1  trace consumer ready
- tr_addr  out  XLEN  head entry address
- tr_data  out  XLEN  head entry data
- tr_overflow  out  1  sticky: a store was dropped

## Operation
- FSM states IDLE, LOAD, RUN. Reset → IDLE.
- IDLE/RUN/LOAD + ld_start → LOAD: load_count←0, ld_trunc←0, trace FIFO emptied, tr_overflow←0, core_rstn←0 next cycle.
- ld_ready = (state==LOAD) && !ld_start && load_count<CAP (combinational).
- Handshake in LOAD: word registered into imem port; load_count increments.
- Exit LOAD → RUN on handshake with ld_last=1, or on handshake making load_count==CAP with ld_last=0 (ld_trunc←1).
- No handshake: imem_web=1, imem_din/imem_addr hold last values.
- core_rstn=1 only in RUN, from second RUN cycle onward.
- Trace push: state==RUN && core_rstn && mem_wrM. Entry {ALU_resultM, wr_dataM}.
- Push when full and no pop: entry dropped, tr_overflow←1 (cleared only by rstn or ld_start).
- Push and pop same cycle when full: both take effect, occupancy unchanged, no overflow.
- Pop: tr_valid && tr_ready. tr_addr/tr_data show head, stable while tr_valid && !tr_ready.
- mem_wrM ignored outside RUN or while core_rstn=0.

## Timing
- Reset values: ld_ready 0, imem_web 1, imem_din 0, imem_addr 0, core_rstn 0, load_count 0, ld_trunc 0, tr_valid 0, tr_addr 0, tr_data 0, tr_overflow 0.
- Handshake at edge t → at t+1: imem_web=0, imem_din=word, imem_addr=BOOT_ADDR+4·(count before increment); one cycle only.
- Final handshake at t: state RUN at t+1 (final write also at t+1); core_rstn=1 at t+2.
- Trace push at t → tr_valid=1 at t+1, no combinational fall-through. Throughput one push and one pop per cycle.
- rstn low at any cycle, including mid-load or a full FIFO: all state to reset values at next edge; a partially issued write is not completed.
- ld_start during LOAD restarts the session. The word presented that cycle is not accepted, because ld_ready=0.
- load_count holds its final value through RUN until the next ld_start.

## Test plan
- Reset, ld_start, stream 3 words 0x00500093, 0x00A00113, 0x002081B3 (last on third), BOOT_ADDR=0 → imem writes at 0x0,0x4,0x8 one cycle after each handshake, load_count=3, core_rstn rises 2 cycles after final handshake.
- IMEM_AW=2, stream 5 words with ld_last never set → 4 writes (0x0–0xC), ld_ready drops after 4th, ld_trunc=1, RUN entered.
- RUN, tr_ready=0, mem_wrM high for 10 cycles with addr 0x100+4i, data i, TRACE_DEPTH=8 → 8 entries held, tr_overflow=1; drain gives addr 0x100..0x11C in order.
- FIFO full, mem_wrM=1 and tr_ready=1 same cycle → head popped, new entry appended, tr_overflow stays 0.
- ld_start asserted mid-load with ld_valid=1 → that word not accepted, load_count=0, next word written at BOOT_ADDR.
- rstn low for one cycle during RUN with FIFO at 5 entries → all outputs at reset values, tr_valid=0, state IDLE, core_rstn=0.

Source files
------------

// File: rtl/core_boot_ctrl.sv
// Boot and observation controller: streams a program into instruction memory while
// holding the core in reset, then releases it and records every data store it issues.
module core_boot_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              IMEM_AW     = 10,
  parameter int              TRACE_DEPTH = 8,
  parameter logic [XLEN-1:0] BOOT_ADDR   = '0
) (
  input  logic               clk,
  input  logic               rstn,
  // Load stream. A word transfers on a rising edge where ld_valid && ld_ready.
  // ld_ready may be sampled combinationally. ld_valid may be held while waiting.
  // Trace stream: the same rule applies to tr_valid && tr_ready.
  input  logic               ld_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [XLEN-1:0]    ld_data,
  input  logic               ld_last,
  output logic [XLEN-1:0]    imem_din,
  output logic [XLEN-1:0]    imem_addr,
  output logic               imem_web,
  output logic               core_rstn,
  output logic [IMEM_AW:0]   load_count,
  output logic               ld_trunc,
  input  logic               mem_wrM,
  input  logic [XLEN-1:0]    ALU_resultM,
  input  logic [XLEN-1:0]    wr_dataM,
  output logic               tr_valid,
  input  logic               tr_ready,
  output logic [XLEN-1:0]    tr_addr,
  output logic [XLEN-1:0]    tr_data,
  output logic               tr_overflow,
  output logic [1:0]         fsm_state
);

  localparam int              PW       = $clog2(TRACE_DEPTH);
  localparam logic [IMEM_AW:0] CAP      = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] LAST_IDX = CAP - 1'b1;
  localparam logic [PW:0]     DEPTH_C  = (PW+1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t state, state_nxt;
  logic   ld_fire, trunc_set;

  assign fsm_state = state;
  assign ld_ready  = (state == LOAD) && !ld_start && (load_count < CAP);
  assign ld_fire   = ld_valid && ld_ready;
  assign trunc_set = ld_fire && !ld_last && (load_count == LAST_IDX);

  always_comb begin
    state_nxt = state;
    if (ld_start)
      state_nxt = LOAD;
    else if (ld_fire && (ld_last || load_count == LAST_IDX))
      state_nxt = RUN;
  end

  // core_rstn is a registered copy of "in RUN", so it rises on the second RUN cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      load_count <= '0;
      ld_trunc   <= 1'b0;
      imem_web   <= 1'b1;
      imem_din   <= '0;
      imem_addr  <= '0;
      core_rstn  <= 1'b0;
    end else begin
      state     <= state_nxt;
      imem_web  <= 1'b1;
      core_rstn <= (state == RUN) && !ld_start;
      if (ld_start) begin
        load_count <= '0;
        ld_trunc   <= 1'b0;
      end else if (ld_fire) begin
        imem_web   <= 1'b0;
        imem_din   <= ld_data;
        imem_addr  <= BOOT_ADDR + XLEN'({load_count, 2'b00});
        load_count <= load_count + 1'b1;
        if (trunc_set)
          ld_trunc <= 1'b1;
      end
    end
  end

  // Store-trace FIFO
  logic [XLEN-1:0] fifo_addr [TRACE_DEPTH];
  logic [XLEN-1:0] fifo_data [TRACE_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, push_req, push, pop;

  assign full     = (count == DEPTH_C);
  assign tr_valid = (count != '0);
  assign push_req = (state == RUN) && core_rstn && mem_wrM && !ld_start;
  assign pop      = tr_valid && tr_ready && !ld_start;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign tr_addr  = tr_valid ? fifo_addr[rd_ptr] : '0;
  assign tr_data  = tr_valid ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rstn || ld_start) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tr_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (push_req && full && !pop)
        tr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      fifo_addr[wr_ptr] <= ALU_resultM;
      fifo_data[wr_ptr] <= wr_dataM;
    end
  end

endmodule
